leak_shreg_bank: RTL and testbench
==================================

LEAK_SHREG_BANK -- requirements
Module: leak_shreg_bank

Interface
REQ-001 Parameter NUM_CH, default 8: number of round-key channels, legal 1..16.
REQ-002 Parameter SHREG_W, default 8: width of each per-channel rotating register, legal 2..32.
REQ-003 Parameter TAP_W, default 8: low-order state/key bits folded per channel, legal 1..128.
REQ-004 Parameter TRIG_PATTERN, default 128'h00112233_44556677_8899aabb_ccddeeff: state value that counts as a trigger hit.
REQ-005 Parameter TRIG_COUNT, default 1: hits needed to activate, legal 1..255.
REQ-006 Parameter SHREG_INIT, default all-ones/zeros alternating (8'hAA at SHREG_W=8; LSB 0): reset load value of every register.
REQ-007 Parameter DISARM_CYCLES, default 1024: ACTIVE dwell length, legal 1..65535; used only under REQ-029.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst  input  1  reset, synchronous, active-low.
REQ-010 state_valid  input  1  qualifies state for trigger matching.
REQ-011 state  input  128  current cipher state.
REQ-012 rk  input  NUM_CH*128  packed round keys; channel c occupies rk[c*128 +: 128].
REQ-013 active  output  1  high while FSM is in ACTIVE.
REQ-014 enable  output  NUM_CH  registered per-channel rotate enable.
REQ-015 shreg  output  NUM_CH*SHREG_W  packed register contents; channel c at shreg[c*SHREG_W +: SHREG_W].
REQ-016 hit_cnt  output  8  current trigger hit count.

Function
REQ-017 FSM states IDLE, ARMED, ACTIVE; encoding is implementer's choice.
REQ-018 A hit is a cycle with state_valid=1 and state==TRIG_PATTERN; state_valid=0 cycles are never hits.
REQ-019 IDLE: on a hit, hit_cnt increments; go to ARMED if TRIG_COUNT>1, else straight to ACTIVE.
REQ-020 ARMED: each hit increments hit_cnt; the hit bringing hit_cnt to TRIG_COUNT moves FSM to ACTIVE next cycle; non-matching valid cycles do not clear hit_cnt.
REQ-021 hit_cnt saturates at TRIG_COUNT and holds while ACTIVE.
REQ-022 ACTIVE is sticky until reset (unless REQ-029); further hits have no effect.
REQ-023 Fold f[c] = XOR-reduce(state[TAP_W-1:0] & rk_c[TAP_W-1:0]), evaluated combinationally every cycle.
REQ-024 enable[c] registered: enable[c] <= active & f[c]; one-cycle latency from state/rk to enable; active is the registered FSM output.
REQ-025 When enable[c]=1 at a rising edge, shreg_c rotates right by one: {q[0], q[SHREG_W-1:1]}; otherwise holds.
REQ-026 Channels are independent; any subset may rotate in the same cycle.
REQ-027 Rotation wraps: SHREG_W consecutive enables return shreg_c to its prior value.

Reset
REQ-028 With rst=0 at a rising edge: FSM=IDLE, active=0, hit_cnt=0, enable=0, every shreg_c=SHREG_INIT; reset mid-ACTIVE or mid-ARMED takes priority over hits and rotations in that cycle.

Configuration
REQ-029 Macro LEAK_SHREG_AUTO_DISARM_EN defined: a 16-bit dwell counter loads 0 on ACTIVE entry, increments each ACTIVE cycle, and after DISARM_CYCLES cycles FSM returns to IDLE with hit_cnt=0 and enable cleared the following cycle; shreg contents are kept.
REQ-030 Macro undefined: no dwell counter is built; ACTIVE persists until reset per REQ-022.

Verification
REQ-031 Reset then state=TRIG_PATTERN, state_valid=1 one cycle, TRIG_COUNT=1 -> active=1 next cycle, hit_cnt=1.
REQ-032 TRIG_COUNT=3, pattern presented on cycles 1,4,9 with other valid states between -> active rises after cycle 9 only; pattern with state_valid=0 never counts.
REQ-033 ACTIVE, state[7:0]=8'h01, rk ch0[7:0]=8'h01, ch1[7:0]=8'h02 -> enable=…01 one cycle later; shreg ch0 8'hAA->8'h55, ch1 stays 8'hAA.
REQ-034 ACTIVE with f[0]=1 held 8 cycles (SHREG_W=8) -> shreg ch0 alternates 55/AA and equals 8'hAA after the 8th rotation.
REQ-035 rst=0 asserted in same cycle as a hit and enable=1 -> next cycle active=0, hit_cnt=0, all shreg=8'hAA.
REQ-036 With LEAK_SHREG_AUTO_DISARM_EN, DISARM_CYCLES=4 -> active high exactly 4 cycles, then IDLE, hit_cnt=0, shreg unchanged; without the macro active stays high 10000 cycles.

Source files
------------

// File: rtl/leak_shreg_bank.sv
// Trigger-armed bank of per-channel rotating registers driven by a state/round-key fold.
// Optional build macro LEAK_SHREG_AUTO_DISARM_EN adds a dwell counter that returns ACTIVE to IDLE.
module leak_shreg_bank #(
  parameter int                 NUM_CH        = 8,
  parameter int                 SHREG_W       = 8,
  parameter int                 TAP_W         = 8,
  parameter logic [127:0]       TRIG_PATTERN  = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter int                 TRIG_COUNT    = 1,
  parameter logic [SHREG_W-1:0] SHREG_INIT    = SHREG_W'({16{2'b10}}),
  parameter int                 DISARM_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        state_valid,
  input  logic [127:0]                state,
  input  logic [NUM_CH*128-1:0]       rk,
  output logic                        active,
  output logic [NUM_CH-1:0]           enable,
  output logic [NUM_CH*SHREG_W-1:0]   shreg,
  output logic [7:0]                  hit_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] HIT_TARGET = 8'(TRIG_COUNT);

  logic [1:0]        fsm_q;
  logic [1:0]        fsm_d;
  logic [7:0]        hit_cnt_q;
  logic [7:0]        hit_cnt_d;
  logic              hit;
  logic [NUM_CH-1:0] fold;
  logic [NUM_CH-1:0] enable_q;

  assign hit    = state_valid && (state == TRIG_PATTERN);
  assign active = (fsm_q == ST_ACTIVE);

`ifdef LEAK_SHREG_AUTO_DISARM_EN
  localparam logic [15:0] DWELL_LAST = 16'(DISARM_CYCLES - 1);

  logic [15:0] dwell_q;
  logic        dwell_done;

  assign dwell_done = (dwell_q == DWELL_LAST);

  // Counter sits at zero outside ACTIVE so the first ACTIVE cycle sees 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_q <= 16'd0;
    end else if (fsm_q != ST_ACTIVE) begin
      dwell_q <= 16'd0;
    end else begin
      dwell_q <= dwell_q + 16'd1;
    end
  end
`else
  logic dwell_done;
  assign dwell_done = 1'b0;
`endif

  always_comb begin
    fsm_d     = fsm_q;
    hit_cnt_d = hit_cnt_q;
    case (fsm_q)
      ST_IDLE, ST_ARMED: begin
        if (hit) begin
          hit_cnt_d = hit_cnt_q + 8'd1;
          fsm_d     = (hit_cnt_d == HIT_TARGET) ? ST_ACTIVE : ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (dwell_done) begin
          fsm_d     = ST_IDLE;
          hit_cnt_d = 8'd0;
        end
      end
      default: begin
        fsm_d     = ST_IDLE;
        hit_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q     <= ST_IDLE;
      hit_cnt_q <= 8'd0;
    end else begin
      fsm_q     <= fsm_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_fold
      assign fold[c] = ^(state[TAP_W-1:0] & rk[c*128 +: TAP_W]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_q <= '0;
    end else begin
      enable_q <= {NUM_CH{active}} & fold;
    end
  end

  assign enable = enable_q;

  // Each channel rotates right independently on its own registered enable.
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_shreg
      logic [SHREG_W-1:0] q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          q <= SHREG_INIT;
        end else if (enable_q[c]) begin
          q <= {q[0], q[SHREG_W-1:1]};
        end
      end

      assign shreg[c*SHREG_W +: SHREG_W] = q;
    end
  endgenerate

endmodule

// File: tb/tb_leak_shreg_bank.sv
// Randomized self-checking bench for leak_shreg_bank: two instances (trigger count 1 and 3)
// share stimulus and are compared every cycle against a behavioural model.
module tb_leak_shreg_bank;

  localparam int NUM_CH  = 8;
  localparam int SHREG_W = 8;
  localparam int TAP_W   = 8;
  localparam int DC      = 4;
  localparam logic [127:0] PAT = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b0;
  logic                      state_valid = 1'b0;
  logic [127:0]              state = '0;
  logic [NUM_CH*128-1:0]     rk = '0;

  logic                      act_a, act_b;
  logic [NUM_CH-1:0]         en_a, en_b;
  logic [NUM_CH*SHREG_W-1:0] sh_a, sh_b;
  logic [7:0]                cnt_a, cnt_b;

  leak_shreg_bank #(.NUM_CH(NUM_CH), .SHREG_W(SHREG_W), .TAP_W(TAP_W),
                    .TRIG_COUNT(1), .DISARM_CYCLES(DC)) dut_a (
    .clk(clk), .rst(rst), .state_valid(state_valid), .state(state), .rk(rk),
    .active(act_a), .enable(en_a), .shreg(sh_a), .hit_cnt(cnt_a));

  leak_shreg_bank #(.NUM_CH(NUM_CH), .SHREG_W(SHREG_W), .TAP_W(TAP_W),
                    .TRIG_COUNT(3), .DISARM_CYCLES(DC)) dut_b (
    .clk(clk), .rst(rst), .state_valid(state_valid), .state(state), .rk(rk),
    .active(act_b), .enable(en_b), .shreg(sh_b), .hit_cnt(cnt_b));

  int total = 0;
  int bad   = 0;

  int tc[2] = '{1, 3};
  bit m_act[2];
  int m_cnt[2];
  int m_dwell[2];
  bit m_en[2][NUM_CH];
  int m_sh[2][NUM_CH];

  function automatic int rot_right(int v);
    return (v >> 1) | ((v & 1) << (SHREG_W - 1));
  endfunction

  function automatic bit fold_bit(int c);
    logic [TAP_W-1:0] s, k;
    s = state[TAP_W-1:0];
    k = rk[c*128 +: TAP_W];
    return ($countones(s & k) % 2) == 1;
  endfunction

  // Advance the behavioural model by one rising edge using the inputs held across it.
  task automatic modelStep();
    bit hit;
    bit new_en[NUM_CH];
    hit = state_valid && (state == PAT);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_act[i] = 0; m_cnt[i] = 0; m_dwell[i] = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          m_en[i][c] = 0;
          m_sh[i][c] = 'hAA;
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_en[i][c]) m_sh[i][c] = rot_right(m_sh[i][c]);
          new_en[c] = m_act[i] && fold_bit(c);
        end
        for (int c = 0; c < NUM_CH; c++) m_en[i][c] = new_en[c];
        if (m_act[i]) begin
`ifdef LEAK_SHREG_AUTO_DISARM_EN
          if (m_dwell[i] == DC - 1) begin
            m_act[i] = 0;
            m_cnt[i] = 0;
          end else begin
            m_dwell[i]++;
          end
`endif
        end else if (hit) begin
          m_cnt[i]++;
          if (m_cnt[i] == tc[i]) begin
            m_act[i]   = 1;
            m_dwell[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*SHREG_W-1:0] exp_sh(int i);
    logic [NUM_CH*SHREG_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*SHREG_W +: SHREG_W] = SHREG_W'(m_sh[i][c]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_en(int i);
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_en[i][c];
    return v;
  endfunction

  task automatic checkOutput();
    check("a_active",  128'(act_a), 128'(m_act[0]));
    check("a_hit_cnt", 128'(cnt_a), 128'(m_cnt[0]));
    check("a_enable",  128'(en_a),  128'(exp_en(0)));
    check("a_shreg",   128'(sh_a),  128'(exp_sh(0)));
    check("b_active",  128'(act_b), 128'(m_act[1]));
    check("b_hit_cnt", 128'(cnt_b), 128'(m_cnt[1]));
    check("b_enable",  128'(en_b),  128'(exp_en(1)));
    check("b_shreg",   128'(sh_b),  128'(exp_sh(1)));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [127:0] s,
                               input logic [NUM_CH*128-1:0] k);
    rst = r; state_valid = v; state = s; rk = k;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [127:0] rand_state();
    logic [127:0] s;
    s = {$urandom, $urandom, $urandom, $urandom};
    if (s == PAT) s[0] = ~s[0];
    return s;
  endfunction

  function automatic logic [NUM_CH*128-1:0] rand_rk();
    logic [NUM_CH*128-1:0] k;
    for (int w = 0; w < NUM_CH*4; w++) k[w*32 +: 32] = $urandom;
    return k;
  endfunction

  logic [NUM_CH*128-1:0] k0;
  logic [127:0]          s01;
  logic [63:0]           all_aa;

  initial begin
    all_aa = {8{8'hAA}};
    s01    = 128'h01;

    // Reset state
    applyStimulus(0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0);
    check("lit_reset_active", 128'(act_a), 128'd0);
    check("lit_reset_cnt",    128'(cnt_a), 128'd0);
    check("lit_reset_shreg",  128'(sh_a),  128'(all_aa));

    // Single hit activates the count-1 instance; count-3 instance needs hits on cycles 1,4,9
    applyStimulus(1, 1, PAT, '0);
    check("lit_c1_active", 128'(act_a), 128'd1);
    check("lit_c1_cnt",    128'(cnt_a), 128'd1);
    check("lit_c3_cnt1",   128'(cnt_b), 128'd1);
    applyStimulus(1, 0, PAT, '0);
    applyStimulus(1, 1, rand_state(), '0);
    applyStimulus(1, 1, PAT, '0);
    check("lit_c3_cnt2", 128'(cnt_b), 128'd2);
    applyStimulus(1, 1, rand_state(), '0);
    applyStimulus(1, 0, PAT, '0);
    applyStimulus(1, 1, rand_state(), '0);
    applyStimulus(1, 0, PAT, '0);
    check("lit_c3_not_yet", 128'(act_b), 128'd0);
    applyStimulus(1, 1, PAT, '0);
    check("lit_c3_active", 128'(act_b), 128'd1);
    check("lit_c3_cnt3",   128'(cnt_b), 128'd3);

    // Fold on ch0 only: one-cycle enable latency, then one rotation
    k0 = '0;
    k0[0*128 +: 8] = 8'h01;
    k0[1*128 +: 8] = 8'h02;
    applyStimulus(1, 0, s01, k0);
    check("lit_en_ch0", 128'(en_b), 128'h01);
    applyStimulus(1, 0, '0, k0);
    check("lit_rot_ch0", 128'(sh_b[7:0]),  128'h55);
    check("lit_rot_ch1", 128'(sh_b[15:8]), 128'hAA);

    // Eight consecutive rotations on ch2 wrap back to the start value
    k0 = '0;
    k0[2*128 +: 8] = 8'h01;
    for (int n = 0; n < SHREG_W; n++) applyStimulus(1, 0, s01, k0);
    applyStimulus(1, 0, '0, k0);
`ifndef LEAK_SHREG_AUTO_DISARM_EN
    check("lit_wrap_ch2", 128'(sh_a[23:16]), 128'hAA);
`endif

    // Reset wins over a hit and an asserted enable in the same cycle
    applyStimulus(0, 0, '0, '0);
    k0 = '0;
    k0[0*128 +: 8] = 8'h01;
    applyStimulus(1, 1, PAT, k0);
    applyStimulus(1, 1, PAT, k0);
    check("lit_pre_rst_en", 128'(en_a), 128'h01);
    applyStimulus(0, 1, PAT, k0);
    check("lit_rst_active", 128'(act_a), 128'd0);
    check("lit_rst_cnt",    128'(cnt_b), 128'd0);
    check("lit_rst_shreg",  128'(sh_a),  128'(all_aa));

    // Randomized traffic with occasional resets and frequent pattern hits
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? PAT : rand_state(), rand_rk());
    end

    // Long dwell after activation
    applyStimulus(0, 0, '0, '0);
    applyStimulus(1, 1, PAT, '0);
    for (int n = 0; n < 10000; n++) applyStimulus(1, $urandom_range(0, 1), rand_state(), rand_rk());
`ifndef LEAK_SHREG_AUTO_DISARM_EN
    check("lit_sticky_active", 128'(act_a), 128'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
